// File: rtl/dps_pkg.sv
// ============================================================================
// Module   : dps_pkg
// Brief    : Shared state encoding for the digital pixel sensor frame sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dps_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ERASE   = 3'd1,
        EXPOSE  = 3'd2,
        CONVERT = 3'd3,
        READ    = 3'd4
    } dps_state_t;

endpackage : dps_pkg

`default_nettype wire

// File: rtl/dps_phase_counter.sv
// ============================================================================
// Module   : dps_phase_counter
// Brief    : Phase duration up-counter with sync clear and terminal-count flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dps_phase_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_last = (r_count == (i_len - CNT_W'(1)));

endmodule : dps_phase_counter

`default_nettype wire

// File: rtl/dps_frame_controller.sv
// ============================================================================
// Module   : dps_frame_controller
// Brief    : ERASE/EXPOSE/CONVERT/READ frame sequencer with ADC ramp and row select.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dps_frame_controller
    import dps_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ROWS         = 4,
    parameter int ROW_W        = 2,
    parameter int CNT_W        = 16,
    parameter int ERASE_CYCLES = 5,
    parameter int READ_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              continuous,
    input  logic [CNT_W-1:0]  expose_len,
    output logic              erase,
    output logic              expose,
    output logic              convert,
    output logic              read,
    output logic [ROW_W-1:0]  row_sel,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              busy,
    output logic              frame_done
);

    localparam int SUB_W = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;

    localparam logic [CNT_W-1:0] c_erase_n   = CNT_W'(ERASE_CYCLES);
    localparam logic [CNT_W-1:0] c_convert_n = CNT_W'(2 ** DATA_W);
    localparam logic [CNT_W-1:0] c_read_n    = CNT_W'(ROWS * READ_CYCLES);
    localparam logic [SUB_W-1:0] c_sub_last  = SUB_W'(READ_CYCLES - 1);

    dps_state_t        r_state;
    dps_state_t        w_next_state;
    logic [CNT_W-1:0]  r_expose_len;
    logic [CNT_W-1:0]  w_phase_len;
    logic              w_last;
    logic              w_clear;
    logic              w_latch;
    logic [DATA_W-1:0] r_ramp;
    logic [ROW_W-1:0]  r_row;
    logic [SUB_W-1:0]  r_sub;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_phase_len  = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = ERASE;
                    w_latch      = 1'b1;
                end
            end
            ERASE: begin
                w_phase_len = c_erase_n;
                if (w_last) w_next_state = EXPOSE;
            end
            EXPOSE: begin
                w_phase_len = r_expose_len;
                if (w_last) w_next_state = CONVERT;
            end
            CONVERT: begin
                w_phase_len = c_convert_n;
                if (w_last) w_next_state = READ;
            end
            READ: begin
                w_phase_len = c_read_n;
                if (w_last) begin
                    if (continuous) begin
                        w_next_state = ERASE;
                        w_latch      = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
        // Abort outranks every transition, including a start seen in IDLE.
        if (abort) begin
            w_next_state = IDLE;
            w_latch      = 1'b0;
        end
    end

    // Counter restarts on every phase change and is held at zero in IDLE.
    assign w_clear = (w_next_state != r_state) || (r_state == IDLE);

    dps_phase_counter #(
        .CNT_W (CNT_W)
    ) u_phase_counter (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_clear),
        .i_len   (w_phase_len),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expose_len <= CNT_W'(1);
        end else if (w_latch) begin
            r_expose_len <= (expose_len == '0) ? CNT_W'(1) : expose_len;
        end
    end

    // Ramp and row trackers run only while the phase persists, so they are zero on entry and exit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ramp <= '0;
            r_row  <= '0;
            r_sub  <= '0;
        end else begin
            if ((r_state == CONVERT) && (w_next_state == CONVERT)) begin
                r_ramp <= r_ramp + DATA_W'(1);
            end else begin
                r_ramp <= '0;
            end
            if ((r_state == READ) && (w_next_state == READ)) begin
                if (r_sub == c_sub_last) begin
                    r_sub <= '0;
                    r_row <= r_row + ROW_W'(1);
                end else begin
                    r_sub <= r_sub + SUB_W'(1);
                end
            end else begin
                r_sub <= '0;
                r_row <= '0;
            end
        end
    end

    assign erase      = (r_state == ERASE);
    assign expose     = (r_state == EXPOSE);
    assign convert    = (r_state == CONVERT);
    assign read       = (r_state == READ);
    assign busy       = (r_state != IDLE);
    assign data_oe    = convert;
    assign data_out   = r_ramp;
    assign row_sel    = r_row;
    assign frame_done = read && w_last && !abort;

endmodule : dps_frame_controller

`default_nettype wire

// File: tb/tb_dps_frame_controller.sv
// ============================================================================
// Module   : tb_dps_frame_controller
// Brief    : Scoreboard bench for the frame sequencer at default parameters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dps_frame_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] expose_len = 16'd10;
    logic        erase, expose, convert, read, data_oe, busy, frame_done;
    logic [1:0]  row_sel;
    logic [7:0]  data_out;

    int checks = 0;
    int failures = 0;
    logic [16:0] exp_q[$];
    logic [16:0] obs;

    assign obs = {erase, expose, convert, read, row_sel, data_out, data_oe, busy, frame_done};

    always #5 clk = ~clk;

    dps_frame_controller dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .continuous (continuous),
        .expose_len (expose_len),
        .erase      (erase),
        .expose     (expose),
        .convert    (convert),
        .read       (read),
        .row_sel    (row_sel),
        .data_out   (data_out),
        .data_oe    (data_oe),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back(17'd0);
    endtask

    // Expected per-cycle outputs for one frame, truncated after `limit` cycles.
    task automatic push_frame(input int explen, input int limit);
        int el;
        int idx;
        el  = (explen == 0) ? 1 : explen;
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            if (idx < limit) exp_q.push_back({4'b1000, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0});
            idx++;
        end
        for (int i = 0; i < el; i++) begin
            if (idx < limit) exp_q.push_back({4'b0100, 2'd0, 8'd0, 1'b0, 1'b1, 1'b0});
            idx++;
        end
        for (int i = 0; i < 256; i++) begin
            if (idx < limit) exp_q.push_back({4'b0010, 2'd0, 8'(i), 1'b1, 1'b1, 1'b0});
            idx++;
        end
        for (int i = 0; i < 8; i++) begin
            if (idx < limit) exp_q.push_back({4'b0001, 2'(i / 2), 8'd0, 1'b0, 1'b1, (i == 7)});
            idx++;
        end
    endtask

    task automatic test_reset();
        int n;
        logic [16:0] e;
        #1;
        checks++;
        if (obs !== 17'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs, 17'd0);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        push_idle(3);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_single_frame();
        int n;
        logic [16:0] e;
        @(negedge clk);
        expose_len = 16'd10;
        start = 1'b1;
        push_frame(10, 100000);
        push_idle(3);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL single_frame cyc=%0d got=%h exp=%h", i, obs, e);
            end
            if (i == 0) start = 1'b0;
        end
    endtask

    task automatic test_expose_zero();
        int n;
        int busy_cnt;
        logic [16:0] e;
        busy_cnt = 0;
        @(negedge clk);
        expose_len = 16'd0;
        start = 1'b1;
        push_frame(0, 100000);
        push_idle(2);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL expose_zero cyc=%0d got=%h exp=%h", i, obs, e);
            end
            if (i == 0) start = 1'b0;
        end
        checks++;
        if (busy_cnt !== 270) begin
            failures++;
            $display("FAIL expose_zero_len got=%0d exp=%0d", busy_cnt, 270);
        end
    endtask

    task automatic test_continuous();
        int n;
        logic [16:0] e;
        @(negedge clk);
        expose_len = 16'd10;
        continuous = 1'b1;
        start = 1'b1;
        push_frame(10, 100000);
        push_frame(20, 100000);
        push_idle(2);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL continuous cyc=%0d got=%h exp=%h", i, obs, e);
            end
            if (i == 0)   start = 1'b0;
            if (i == 100) expose_len = 16'd20;
            if (i == 300) continuous = 1'b0;
        end
    endtask

    task automatic test_abort();
        int n;
        logic [16:0] e;
        @(negedge clk);
        expose_len = 16'd10;
        start = 1'b1;
        // Cycle 114 is the 100th CONVERT cycle (ramp 99); abort is sampled at its closing edge.
        push_frame(10, 115);
        push_idle(3);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL abort cyc=%0d got=%h exp=%h", i, obs, e);
            end
            if (i == 0)   start = 1'b0;
            if (i == 114) abort = 1'b1;
            if (i == 115) abort = 1'b0;
        end
        @(negedge clk);
        start = 1'b1;
        push_frame(10, 100000);
        push_idle(2);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL abort_restart cyc=%0d got=%h exp=%h", i, obs, e);
            end
            if (i == 0) start = 1'b0;
        end
    endtask

    task automatic test_reset_mid_expose();
        int n;
        logic [16:0] e;
        @(negedge clk);
        expose_len = 16'd10;
        start = 1'b1;
        push_frame(10, 9);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL pre_reset cyc=%0d got=%h exp=%h", i, obs, e);
            end
            if (i == 0) start = 1'b0;
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== 17'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=%h", obs, 17'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        push_idle(4);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, obs, e);
            end
        end
    endtask

    task automatic test_ignored_start();
        int n;
        logic [16:0] e;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        push_idle(4);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL start_abort_idle cyc=%0d got=%h exp=%h", i, obs, e);
            end
            if (i == 0) begin
                start = 1'b0;
                abort = 1'b0;
            end
        end
        @(negedge clk);
        expose_len = 16'd10;
        start = 1'b1;
        push_frame(10, 100000);
        push_idle(2);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL start_in_expose cyc=%0d got=%h exp=%h", i, obs, e);
            end
            if (i == 0) start = 1'b0;
            if (i == 7) start = 1'b1;
            if (i == 8) start = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_expose_zero();
        test_continuous();
        test_abort();
        test_reset_mid_expose();
        test_ignored_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dps_frame_controller

`default_nettype wire
